// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decoded instruction and operands in, ID/EX register
// contents, hazard freeze and performance counters out.
interface id_ex_if #(
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 32
);
   logic              id_valid;
   logic [31:0]       id_pc;
   logic [4:0]        id_rs1;
   logic [4:0]        id_rs2;
   logic [4:0]        id_rd;
   logic              id_uses_rs1;
   logic              id_uses_rs2;
   logic [31:0]       id_rdata1;
   logic [31:0]       id_rdata2;
   logic [31:0]       id_imm;
   logic [CTRL_W-1:0] id_ctrl;
   logic              id_regwrite;
   logic              id_memread;
   logic              flush;
   logic              ext_stall;

   logic              ex_valid;
   logic [31:0]       ex_pc;
   logic [4:0]        ex_rs1;
   logic [4:0]        ex_rs2;
   logic [4:0]        ex_rd;
   logic [31:0]       ex_rdata1;
   logic [31:0]       ex_rdata2;
   logic [31:0]       ex_imm;
   logic [CTRL_W-1:0] ex_ctrl;
   logic              ex_regwrite;
   logic              ex_memread;
   logic              hazard_stall;
   logic [CNT_W-1:0]  hazard_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_rdata1, id_rdata2, id_imm, id_ctrl, id_regwrite, id_memread,
             flush, ext_stall,
      input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2,
             ex_imm, ex_ctrl, ex_regwrite, ex_memread, hazard_stall,
             hazard_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_rdata1, id_rdata2, id_imm, id_ctrl, id_regwrite, id_memread,
             flush, ext_stall,
      output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2,
             ex_imm, ex_ctrl, ex_regwrite, ex_memread, hazard_stall,
             hazard_cnt, flush_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/hold handling and saturating hazard/flush counters.
module id_ex_stage #(
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 32
) (
   input logic    clk,
   input logic    rst_n,
   id_ex_if.slave bus
);
   typedef struct packed {
      logic              valid;
      logic [31:0]       pc;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic [31:0]       rdata1;
      logic [31:0]       rdata2;
      logic [31:0]       imm;
      logic [CTRL_W-1:0] ctrl;
      logic              regwrite;
      logic              memread;
   } ex_t;

   ex_t              id_word;
   ex_t              ex_p0;
   logic             rs1_match;
   logic             rs2_match;
   logic             haz;
   logic [CNT_W-1:0] hazard_cnt_p0;
   logic [CNT_W-1:0] flush_cnt_p0;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Decode stage: invalid slots must never write back or look like a load.
   always_comb begin
      id_word          = '0;
      id_word.valid    = bus.id_valid;
      id_word.pc       = bus.id_pc;
      id_word.rs1      = bus.id_rs1;
      id_word.rs2      = bus.id_rs2;
      id_word.rd       = bus.id_rd;
      id_word.rdata1   = bus.id_rdata1;
      id_word.rdata2   = bus.id_rdata2;
      id_word.imm      = bus.id_imm;
      id_word.ctrl     = bus.id_ctrl;
      id_word.regwrite = bus.id_regwrite & bus.id_valid;
      id_word.memread  = bus.id_memread & bus.id_valid;
   end

   // x0 is hardwired, so a load targeting it cannot produce a dependency.
   assign rs1_match = bus.id_uses_rs1 && (bus.id_rs1 == ex_p0.rd);
   assign rs2_match = bus.id_uses_rs2 && (bus.id_rs2 == ex_p0.rd);
   assign haz       = ex_p0.valid && ex_p0.memread && (ex_p0.rd != 5'd0)
                      && bus.id_valid && (rs1_match || rs2_match);

   assign bus.hazard_stall = haz && !bus.flush;

   // ID/EX boundary: flush beats hold, hold beats bubble insertion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_p0 <= '0;
      end else if (bus.flush) begin
         ex_p0 <= '0;
      end else if (bus.ext_stall) begin
         ex_p0 <= ex_p0;
      end else if (haz) begin
         ex_p0 <= '0;
      end else begin
         ex_p0 <= id_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hazard_cnt_p0 <= '0;
         flush_cnt_p0  <= '0;
      end else if (bus.flush) begin
         flush_cnt_p0 <= sat_inc(flush_cnt_p0);
      end else if (!bus.ext_stall && haz) begin
         hazard_cnt_p0 <= sat_inc(hazard_cnt_p0);
      end
   end

   assign bus.ex_valid    = ex_p0.valid;
   assign bus.ex_pc       = ex_p0.pc;
   assign bus.ex_rs1      = ex_p0.rs1;
   assign bus.ex_rs2      = ex_p0.rs2;
   assign bus.ex_rd       = ex_p0.rd;
   assign bus.ex_rdata1   = ex_p0.rdata1;
   assign bus.ex_rdata2   = ex_p0.rdata2;
   assign bus.ex_imm      = ex_p0.imm;
   assign bus.ex_ctrl     = ex_p0.ctrl;
   assign bus.ex_regwrite = ex_p0.regwrite;
   assign bus.ex_memread  = ex_p0.memread;
   assign bus.hazard_cnt  = hazard_cnt_p0;
   assign bus.flush_cnt   = flush_cnt_p0;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of the ID/EX update rules.
module tb_id_ex_stage;
   localparam int CTRL_W  = 16;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = 255;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   id_ex_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

   id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: expected ID/EX contents and unbounded event totals.
   typedef struct {
      bit              valid;
      bit [31:0]       pc;
      bit [4:0]        rs1, rs2, rd;
      bit [31:0]       d1, d2, imm;
      bit [CTRL_W-1:0] ctrl;
      bit              rw, mr;
   } rec_t;

   rec_t m;
   int   h_total;
   int   f_total;
   bit   check_en = 1'b0;

   function automatic int sat(input int t);
      return (t > CNT_MAX) ? CNT_MAX : t;
   endfunction

   function automatic bit model_haz();
      return m.valid && m.mr && (m.rd != 5'd0) && bus.id_valid &&
             ((bus.id_uses_rs1 && bus.id_rs1 == m.rd) ||
              (bus.id_uses_rs2 && bus.id_rs2 == m.rd));
   endfunction

   function automatic rec_t from_id();
      rec_t r;
      r.valid = bus.id_valid;
      r.pc    = bus.id_pc;
      r.rs1   = bus.id_rs1;
      r.rs2   = bus.id_rs2;
      r.rd    = bus.id_rd;
      r.d1    = bus.id_rdata1;
      r.d2    = bus.id_rdata2;
      r.imm   = bus.id_imm;
      r.ctrl  = bus.id_ctrl;
      r.rw    = bus.id_valid && bus.id_regwrite;
      r.mr    = bus.id_valid && bus.id_memread;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m       <= '{default: 0};
         h_total <= 0;
         f_total <= 0;
      end else if (bus.flush) begin
         m       <= '{default: 0};
         f_total <= f_total + 1;
      end else if (bus.ext_stall) begin
         m <= m;
      end else if (model_haz()) begin
         m       <= '{default: 0};
         h_total <= h_total + 1;
      end else begin
         m <= from_id();
      end
   end

   always @(negedge clk) begin
      if (check_en && rst_n) begin
         chk("ex_valid",     64'(bus.ex_valid),     64'(m.valid));
         chk("ex_pc",        64'(bus.ex_pc),        64'(m.pc));
         chk("ex_rs1",       64'(bus.ex_rs1),       64'(m.rs1));
         chk("ex_rs2",       64'(bus.ex_rs2),       64'(m.rs2));
         chk("ex_rd",        64'(bus.ex_rd),        64'(m.rd));
         chk("ex_rdata1",    64'(bus.ex_rdata1),    64'(m.d1));
         chk("ex_rdata2",    64'(bus.ex_rdata2),    64'(m.d2));
         chk("ex_imm",       64'(bus.ex_imm),       64'(m.imm));
         chk("ex_ctrl",      64'(bus.ex_ctrl),      64'(m.ctrl));
         chk("ex_regwrite",  64'(bus.ex_regwrite),  64'(m.rw));
         chk("ex_memread",   64'(bus.ex_memread),   64'(m.mr));
         chk("hazard_stall", 64'(bus.hazard_stall), 64'(model_haz() && !bus.flush));
         chk("hazard_cnt",   64'(bus.hazard_cnt),   64'(sat(h_total)));
         chk("flush_cnt",    64'(bus.flush_cnt),    64'(sat(f_total)));
      end
   end

   task automatic set_id(input bit v, input bit [31:0] pc, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit [4:0] rd, input bit u1, input bit u2, input bit [31:0] d1,
                         input bit [31:0] d2, input bit rw, input bit mr);
      bus.id_valid    = v;
      bus.id_pc       = pc;
      bus.id_rs1      = rs1;
      bus.id_rs2      = rs2;
      bus.id_rd       = rd;
      bus.id_uses_rs1 = u1;
      bus.id_uses_rs2 = u2;
      bus.id_rdata1   = d1;
      bus.id_rdata2   = d2;
      bus.id_imm      = pc ^ 32'h5A5A_0000;
      bus.id_ctrl     = pc[15:0] ^ 16'h00FF;
      bus.id_regwrite = rw;
      bus.id_memread  = mr;
   endtask

   task automatic set_random();
      set_id(($urandom_range(0, 4) != 0), $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
             $urandom, $urandom, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      bus.id_imm  = $urandom;
      bus.id_ctrl = 16'($urandom);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.ext_stall = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("reset ex_valid",     64'(bus.ex_valid),     64'd0);
      chk("reset ex_pc",        64'(bus.ex_pc),        64'd0);
      chk("reset hazard_stall", 64'(bus.hazard_stall), 64'd0);
      step();
      rst_n    = 1'b1;
      check_en = 1'b1;

      // Normal flow
      set_id(1, 32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 32'hDEADBEEF, 32'h1234, 1, 0);
      #1;
      chk("normal hazard_stall before", 64'(bus.hazard_stall), 64'd0);
      step();
      chk("normal ex_pc",       64'(bus.ex_pc),        64'h100);
      chk("normal ex_rd",       64'(bus.ex_rd),        64'd3);
      chk("normal ex_rdata1",   64'(bus.ex_rdata1),    64'hDEADBEEF);
      chk("normal ex_valid",    64'(bus.ex_valid),     64'd1);
      chk("normal hazard_stall",64'(bus.hazard_stall), 64'd0);

      // Load-use hazard on rs2
      set_id(1, 32'h104, 5'd0, 5'd0, 5'd5, 0, 0, 0, 0, 1, 1);
      step();
      set_id(1, 32'h108, 5'd1, 5'd5, 5'd6, 1, 1, 32'h11, 32'h22, 1, 0);
      #1;
      chk("loaduse hazard_stall", 64'(bus.hazard_stall), 64'd1);
      step();
      chk("loaduse bubble ex_valid", 64'(bus.ex_valid),     64'd0);
      chk("loaduse hazard_cnt",      64'(bus.hazard_cnt),   64'd1);
      chk("loaduse stall released",  64'(bus.hazard_stall), 64'd0);
      step();
      chk("loaduse dependent ex_pc",    64'(bus.ex_pc),    64'h108);
      chk("loaduse dependent ex_valid", 64'(bus.ex_valid), 64'd1);

      // Hazard negatives: rd=x0, rs2 unused, producer not a load
      for (int k = 0; k < 3; k++) begin
         set_id(1, 32'h200 + 32'(k * 16), 5'd0, 5'd0, (k == 0) ? 5'd0 : 5'd5, 0, 0, 0, 0, 1, (k != 2));
         step();
         set_id(1, 32'h204 + 32'(k * 16), 5'd1, (k == 0) ? 5'd0 : 5'd5, 5'd7, 1, (k != 1), 0, 0, 1, 0);
         #1;
         chk("negative hazard_stall", 64'(bus.hazard_stall), 64'd0);
         step();
         chk("negative ex_valid", 64'(bus.ex_valid), 64'd1);
         chk("negative ex_pc",    64'(bus.ex_pc),    64'(32'h204 + 32'(k * 16)));
      end
      chk("negative hazard_cnt", 64'(bus.hazard_cnt), 64'd1);

      // Flush over hazard
      set_id(1, 32'h300, 5'd0, 5'd0, 5'd5, 0, 0, 0, 0, 1, 1);
      step();
      set_id(1, 32'h304, 5'd1, 5'd5, 5'd6, 1, 1, 0, 0, 1, 0);
      bus.flush = 1'b1;
      #1;
      chk("flush hazard_stall", 64'(bus.hazard_stall), 64'd0);
      step();
      bus.flush = 1'b0;
      chk("flush ex_valid",   64'(bus.ex_valid),   64'd0);
      chk("flush flush_cnt",  64'(bus.flush_cnt),  64'd1);
      chk("flush hazard_cnt", 64'(bus.hazard_cnt), 64'd1);

      // ext_stall hold with changing decode inputs
      set_id(1, 32'h400, 5'd1, 5'd2, 5'd9, 1, 1, 32'hAAAA, 32'hBBBB, 1, 0);
      step();
      bus.ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_random();
         step();
         chk("hold ex_pc",      64'(bus.ex_pc),      64'h400);
         chk("hold ex_rd",      64'(bus.ex_rd),      64'd9);
         chk("hold ex_rdata1",  64'(bus.ex_rdata1),  64'hAAAA);
         chk("hold hazard_cnt", 64'(bus.hazard_cnt), 64'd1);
         chk("hold flush_cnt",  64'(bus.flush_cnt),  64'd1);
      end
      bus.ext_stall = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         set_random();
         bus.flush     = ($urandom_range(0, 9) == 0);
         bus.ext_stall = ($urandom_range(0, 6) == 0);
         step();
      end
      bus.flush     = 1'b0;
      bus.ext_stall = 1'b0;

      // Asynchronous reset mid-operation
      set_id(1, 32'h500, 5'd0, 5'd0, 5'd4, 0, 0, 32'h77, 32'h88, 1, 0);
      step();
      chk("pre-reset ex_valid", 64'(bus.ex_valid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async reset ex_valid",   64'(bus.ex_valid),   64'd0);
      chk("async reset ex_pc",      64'(bus.ex_pc),      64'd0);
      chk("async reset ex_rdata1",  64'(bus.ex_rdata1),  64'd0);
      chk("async reset ex_regwrite",64'(bus.ex_regwrite),64'd0);
      chk("async reset hazard_cnt", 64'(bus.hazard_cnt), 64'd0);
      chk("async reset flush_cnt",  64'(bus.flush_cnt),  64'd0);
      #1 rst_n = 1'b1;

      // Counter saturation
      for (int i = 0; i < CNT_MAX + 3; i++) begin
         set_id(1, 32'h600, 5'd0, 5'd0, 5'd5, 0, 0, 0, 0, 1, 1);
         step();
         set_id(1, 32'h604, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 1, 0);
         step();
      end
      chk("hazard_cnt saturated", 64'(bus.hazard_cnt), 64'(CNT_MAX));
      set_id(1, 32'h600, 5'd0, 5'd0, 5'd5, 0, 0, 0, 0, 1, 1);
      step();
      set_id(1, 32'h604, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 1, 0);
      step();
      chk("hazard_cnt stays saturated", 64'(bus.hazard_cnt), 64'(CNT_MAX));
      bus.flush = 1'b1;
      repeat (CNT_MAX + 3) step();
      bus.flush = 1'b0;
      chk("flush_cnt saturated", 64'(bus.flush_cnt), 64'(CNT_MAX));
      step();

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the register file.
- Latches the decoded instruction together with the two register-file read operands into the ID/EX register.
- Detects load-use hazards, inserts bubbles and requests an IF/ID freeze.
- Applies branch flushes and global memory-wait holds, and keeps saturating hazard and flush performance counters.

Parameters:
CTRL_W, 16, width of the opaque execute/memory/writeback control bundle carried from decode
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  rising-edge clock for all state in this block
rst_n  input  1  asynchronous, active-low reset
id_valid  input  1  decode slot holds a real instruction
id_pc  input  32  PC of the decoded instruction
id_rs1  input  5  source register 1 index, also drives the register file read address
id_rs2  input  5  source register 2 index
id_rd  input  5  destination register index
id_uses_rs1  input  1  instruction actually reads rs1
id_uses_rs2  input  1  instruction actually reads rs2
id_rdata1  input  32  register file read data for rs1
id_rdata2  input  32  register file read data for rs2
id_imm  input  32  sign-extended immediate
id_ctrl  input  CTRL_W  control bundle
id_regwrite  input  1  instruction writes rd
id_memread  input  1  instruction is a load
flush  input  1  branch or jump redirect resolved in EX; squash the decode slot
ext_stall  input  1  global hold, e.g. a data-memory wait
ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_ctrl, ex_regwrite, ex_memread  output  widths as the matching id_* inputs  registered ID/EX contents
hazard_stall  output  1  combinational; freeze PC and IF/ID this cycle
hazard_cnt  output  CNT_W  number of load-use bubbles inserted
flush_cnt  output  CNT_W  number of cycles in which a flush was applied

Behaviour:
- Reset: while rst_n=0, every ex_* output and both counters are 0, asynchronously. After release, the first rising edge of clk performs a normal update.
- Register file timing: the register file writes on the falling edge, so a writeback in the same cycle is already visible on id_rdata*. This block performs no WB-to-ID bypass.
- Hazard condition: haz = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- hazard_stall = haz & !flush. It is purely combinational with zero latency and is 0 during reset.
- Update priority at each rising clk edge, highest first:
  1. flush: load a bubble; flush_cnt += 1.
  2. ext_stall: hold every ex_* field unchanged.
  3. haz: load a bubble; hazard_cnt += 1.
  4. Otherwise: load all id_* fields. ex_valid = id_valid.
- Bubble: ex_valid, ex_regwrite and ex_memread are 0; ex_ctrl, ex_rd, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_rdata1 and ex_rdata2 are all 0.
- Invalid decode: if id_valid=0 on a normal load, ex_regwrite and ex_memread are forced to 0. Other fields are copied.
- Load-use latency: the dependent instruction enters EX exactly one cycle late, after one bubble. Because ex_memread is 0 in the bubble, haz deasserts in the following cycle with no further intervention.
- Counters: saturate at all-ones and never wrap. They are not affected by ext_stall cycles.
- ext_stall with haz: the stage holds, no bubble is inserted and hazard_cnt does not change. hazard_stall is still driven, so the hold is consistent upstream.
- x0: rd=0 never creates a hazard, even for a load to x0.

Test Plan:
- Reset: drive rst_n=0 mid-operation with ex_valid=1 and hazard_cnt=5 -> all ex_* outputs and both counters read 0 immediately, without waiting for a clock edge.
- Normal flow: id_pc=0x100, id_rd=3, id_rdata1=0xDEADBEEF, id_regwrite=1 -> one edge later ex_pc=0x100, ex_rd=3, ex_rdata1=0xDEADBEEF, ex_valid=1; hazard_stall=0 throughout.
- Load-use: EX holds a load with ex_rd=5; ID holds an instruction with rs2=5 and id_uses_rs2=1 -> hazard_stall=1, the next edge gives ex_valid=0 and hazard_cnt=1. The following edge loads the dependent instruction, with hazard_stall=0.
- Hazard negatives: same as the load-use case but with ex_rd=0, or id_uses_rs2=0, or ex_memread=0 -> hazard_stall=0 and no bubble.
- Flush over hazard: flush=1 together with the hazard -> hazard_stall=0, ex_valid=0, flush_cnt=1, hazard_cnt unchanged.
- ext_stall hold, then counter saturation:
  - ext_stall=1 for 3 cycles with changing id_* inputs -> ex_* stays constant and the counters do not change.
  - Preload hazard_cnt to 0xFFFFFFFF through repeated hazards or a forced value, then trigger one more hazard -> hazard_cnt stays 0xFFFFFFFF.
